pdp8_tty: RTL

PDP8_TTY -- requirements
Module: pdp8_tty

---
 rtl/pdp8_tty_pkg.sv | 19 +
 rtl/pdp8_tty_tx.sv | 72 +++++++
 rtl/pdp8_tty.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pdp8_tty_pkg.sv
// Shared PDP-8 console definitions: IOT function-bit masks, default device
// codes and the printer state encoding.
package pdp8_tty_pkg;

  localparam logic [2:0] IOT_SKIP  = 3'b001;
  localparam logic [2:0] IOT_CLEAR = 3'b010;
  localparam logic [2:0] IOT_XFER  = 3'b100;
  localparam logic [2:0] IOT_IE    = 3'b101;

  localparam logic [5:0] KBD_DEV_DEFAULT = 6'o03;
  localparam logic [5:0] PRT_DEV_DEFAULT = 6'o04;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT
  } tx_state_t;

endpackage

// File: rtl/pdp8_tty_tx.sv
// Printer side of the console: holds the character until accepted, then
// models the mechanical print time before reporting completion.
module pdp8_tty_tx
  import pdp8_tty_pkg::*;
#(
  parameter int unsigned TX_DELAY = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] start_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       done
);

  localparam int unsigned CW = (TX_DELAY > 1) ? $clog2(TX_DELAY) : 1;

  tx_state_t      state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [7:0]     prt_buf, prt_buf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      prt_buf <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      prt_buf <= prt_buf_d;
    end
  end

  // Counter is loaded with TX_DELAY-1 on acceptance so done lands exactly
  // TX_DELAY edges after the accepting edge.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    prt_buf_d = prt_buf;
    tx_valid  = 1'b0;
    done      = 1'b0;
    case (state)
      TX_IDLE: begin
        if (start) begin
          prt_buf_d = start_data;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          cnt_d   = CW'(TX_DELAY - 1);
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (cnt == '0) begin
          done    = 1'b1;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_data = prt_buf;

endmodule

// File: rtl/pdp8_tty.sv
// PDP-8 console teletype: keyboard (input) and printer (output) IOT devices
// with flags, skip, data return and a shared interrupt request.
module pdp8_tty
  import pdp8_tty_pkg::*;
#(
  parameter int unsigned TX_DELAY = 100,
  parameter logic [5:0]  KBD_DEV  = KBD_DEV_DEFAULT,
  parameter logic [5:0]  PRT_DEV  = PRT_DEV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [5:0]  io_select,
  input  logic [11:0] io_data_in,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_skip,
  output logic        io_interrupt,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  logic        iot_q;
  logic        kbd_flag, kbd_flag_d;
  logic [7:0]  kbd_buf, kbd_buf_d;
  logic        prt_flag, prt_flag_d;
  logic        int_en, int_en_d;
  logic [11:0] data_d;
  logic        avail_d, skip_d, irq_d;
  logic        fire, kbd_hit, prt_hit;
  logic [2:0]  fn;
  logic        tx_start, tx_done;
  logic        unused_bits;

  assign unused_bits = ^{state, mb[11:3], io_data_in[11:8]};
  assign rx_ready    = !kbd_flag;

  pdp8_tty_tx #(
    .TX_DELAY(TX_DELAY)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .start     (tx_start),
    .start_data(io_data_in[7:0]),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .done      (tx_done)
  );

  // Sets are applied after clears so an arriving character or a finished
  // print wins over a same-edge flag clear.
  always_comb begin
    fn         = mb[2:0];
    fire       = iot && !iot_q;
    kbd_hit    = fire && (io_select == KBD_DEV);
    prt_hit    = fire && (io_select == PRT_DEV);
    kbd_flag_d = kbd_flag;
    kbd_buf_d  = kbd_buf;
    prt_flag_d = prt_flag;
    int_en_d   = int_en;
    data_d     = '0;
    avail_d    = 1'b0;
    skip_d     = 1'b0;
    tx_start   = 1'b0;

    if (kbd_hit) begin
      if (fn == IOT_IE) begin
        int_en_d = io_data_in[0];
      end else begin
        skip_d = |(fn & IOT_SKIP) && kbd_flag;
        if (|(fn & IOT_CLEAR)) begin
          kbd_flag_d = 1'b0;
          avail_d    = 1'b1;
        end
        if (|(fn & IOT_XFER)) begin
          data_d  = {4'b0, kbd_buf};
          avail_d = 1'b1;
        end
      end
    end
    if (rx_valid && rx_ready) begin
      kbd_buf_d  = rx_data;
      kbd_flag_d = 1'b1;
    end

    if (prt_hit) begin
      skip_d = |(fn & IOT_SKIP) && prt_flag;
      if (|(fn & IOT_CLEAR)) prt_flag_d = 1'b0;
      if (fn == 3'b000)      prt_flag_d = 1'b1;
      if (|(fn & IOT_XFER))  tx_start   = 1'b1;
    end
    if (tx_done) prt_flag_d = 1'b1;

    irq_d = int_en_d && (kbd_flag_d || prt_flag_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iot_q         <= 1'b0;
      kbd_flag      <= 1'b0;
      kbd_buf       <= '0;
      prt_flag      <= 1'b0;
      int_en        <= 1'b1;
      io_interrupt  <= 1'b0;
      io_data_out   <= '0;
      io_data_avail <= 1'b0;
      io_skip       <= 1'b0;
    end else begin
      iot_q        <= iot;
      kbd_flag     <= kbd_flag_d;
      kbd_buf      <= kbd_buf_d;
      prt_flag     <= prt_flag_d;
      int_en       <= int_en_d;
      io_interrupt <= irq_d;
      if (fire) begin
        io_data_out   <= data_d;
        io_data_avail <= avail_d;
        io_skip       <= skip_d;
      end else if (!iot) begin
        io_data_out   <= '0;
        io_data_avail <= 1'b0;
        io_skip       <= 1'b0;
      end
    end
  end

endmodule
